spi_host_master: RTL



---
 rtl/spi_host_master_if.sv | 24 ++
 rtl/spi_host_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_host_master_if.sv
// rtl/spi_host_master_if.sv - control handshake and SPI pin bundle for spi_host_master
interface spi_host_master_if;
    logic         START;
    logic         CMD_WRITE;
    logic         CMD_READ;
    logic [255:0] TX_DATA;
    logic         BUSY;
    logic         DONE;
    logic [255:0] RX_DATA;
    logic         SPI_CS;
    logic         SPI_CLK;
    logic         SPI_MOSI;
    logic         SPI_MISO;

    modport master (
        input  START, CMD_WRITE, CMD_READ, TX_DATA, SPI_MISO,
        output BUSY, DONE, RX_DATA, SPI_CS, SPI_CLK, SPI_MOSI
    );

    modport slave (
        output START, CMD_WRITE, CMD_READ, TX_DATA, SPI_MISO,
        input  BUSY, DONE, RX_DATA, SPI_CS, SPI_CLK, SPI_MOSI
    );
endinterface

// File: rtl/spi_host_master.sv
// rtl/spi_host_master.sv - SPI initiator: cmd byte, wait byte, 256 data bits per frame
// Optional MISO 2-flop synchronizer: define SPI_HOST_MASTER_MISO_SYNC_EN.
module spi_host_master #(
    parameter int CLK_DIV  = 16,
    parameter int CS_SETUP = 16,
    parameter int CS_IDLE  = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    spi_host_master_if.master   bus
);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_MAX = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [8:0] LAST_BIT = 9'd271;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic                cs_q;
    logic                sclk_q;
    logic                mosi_q;
    logic                phase_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [8:0]          bit_idx_q;
    logic                cmd_write_q;
    logic                cmd_read_q;
    logic [255:0]        tx_q;
    logic [255:0]        shift_q;
    logic [255:0]        rx_q;
    logic                miso_s;
    logic                mosi_d;
    logic [7:0]          cmd_byte;
    logic [8:0]          nxt_idx;
    logic [7:0]          data_off;
    logic [7:0]          samp_off;

`ifdef SPI_HOST_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_q;
    always_ff @(posedge CLK) begin
        if (RESET) miso_sync_q <= '0;
        else       miso_sync_q <= {miso_sync_q[0], bus.SPI_MISO};
    end
    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = bus.SPI_MISO;
`endif

    assign cmd_byte = {1'b1, cmd_write_q, cmd_read_q, 5'b0};
    assign nxt_idx  = bit_idx_q + 9'd1;
    assign data_off = 8'(nxt_idx - 9'd16);
    assign samp_off = 8'(bit_idx_q - 9'd16);

    // MOSI value for the bit period that starts after the current one
    always_comb begin
        mosi_d = 1'b0;
        if (nxt_idx < 9'd8)
            mosi_d = cmd_byte[3'd7 - nxt_idx[2:0]];
        else if (nxt_idx >= 9'd16 && cmd_write_q)
            mosi_d = tx_q[data_off];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            phase_q     <= 1'b0;
            div_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            bit_idx_q   <= '0;
            cmd_write_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            tx_q        <= '0;
            shift_q     <= '0;
            rx_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        cmd_write_q <= bus.CMD_WRITE;
                        cmd_read_q  <= bus.CMD_READ;
                        tx_q        <= bus.TX_DATA;
                        busy_q      <= 1'b1;
                        cs_q        <= 1'b0;
                        wait_cnt_q  <= '0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (wait_cnt_q == WAIT_W'(CS_SETUP - 1)) begin
                        state_q   <= SHIFT;
                        div_cnt_q <= '0;
                        phase_q   <= 1'b0;
                        bit_idx_q <= '0;
                        // bit 0 is the command byte MSB, always 1
                        mosi_q    <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_cnt_q != DIV_W'(CLK_DIV - 1)) begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end else begin
                        div_cnt_q <= '0;
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                            sclk_q  <= 1'b1;
                            if (bit_idx_q >= 9'd16)
                                shift_q[samp_off] <= miso_s;
                        end else begin
                            phase_q <= 1'b0;
                            sclk_q  <= 1'b0;
                            if (bit_idx_q == LAST_BIT) begin
                                mosi_q  <= 1'b0;
                                state_q <= HOLD;
                            end else begin
                                bit_idx_q <= nxt_idx;
                                mosi_q    <= mosi_d;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (div_cnt_q != DIV_W'(CLK_DIV - 1)) begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end else begin
                        div_cnt_q  <= '0;
                        cs_q       <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    if (wait_cnt_q == WAIT_W'(CS_IDLE - 1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        if (cmd_read_q)
                            rx_q <= shift_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.RX_DATA  = rx_q;
    assign bus.SPI_CS   = cs_q;
    assign bus.SPI_CLK  = sclk_q;
    assign bus.SPI_MOSI = mosi_q;
endmodule
